// File: rtl/monitor_transiciones_if.sv
// Bundle between the adder buses, the read port and the toggle monitor.
// The master drives samples and read requests; the slave answers.
interface monitor_transiciones_if #(
  parameter int ANCHO       = 9,
  parameter int NUM_CANALES = 3,
  parameter int ANCHO_CNT   = 32,
  parameter int ANCHO_DIR   = 3
);
  logic [NUM_CANALES*ANCHO-1:0] datos_in;
  logic                         muestra;
  logic                         borrar;
  logic                         lee;
  logic [ANCHO_DIR-1:0]         dir;
  logic [ANCHO_CNT-1:0]         dato_out;
  logic                         listo;
  logic                         err_dir;
  logic [NUM_CANALES-1:0]       saturado;

  modport master (
    output datos_in, muestra, borrar,
    output lee, dir,
    input  dato_out, listo, err_dir,
    input  saturado
  );

  modport slave (
    input  datos_in, muestra, borrar,
    input  lee, dir,
    output dato_out, listo, err_dir,
    output saturado
  );
endinterface

// File: rtl/monitor_transiciones.sv
// Per-channel bit-toggle counters for the adder output buses,
// with saturating counters and a one-cycle addressed read port.
module monitor_transiciones #(
  parameter int ANCHO       = 9,
  parameter int NUM_CANALES = 3,
  parameter int ANCHO_CNT   = 32,
  parameter int ANCHO_DIR   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  monitor_transiciones_if.slave  bus
);
  localparam int W_INC = $clog2(ANCHO + 1);
  localparam int W_TOT = ANCHO_CNT + 1;
  localparam logic [ANCHO_CNT-1:0] MAX_CNT = '1;

  typedef enum logic {VACIO, CONTANDO} estado_t;
  typedef enum logic {R_IDLE, R_ENTREGA} estado_r_t;

  estado_t              r_estado, w_estado_sig;
  logic                 w_suma;
  logic [ANCHO-1:0]     r_prev [NUM_CANALES];
  logic [ANCHO-1:0]     w_dif  [NUM_CANALES];
  logic [W_INC-1:0]     w_inc  [NUM_CANALES];
  logic [W_TOT-1:0]     w_total [NUM_CANALES];
  logic [ANCHO_CNT-1:0] r_cnt     [NUM_CANALES];
  logic [ANCHO_CNT-1:0] w_cnt_sig [NUM_CANALES];
  logic [NUM_CANALES-1:0] r_sat, w_sat_sig;

  always_comb begin
    w_estado_sig = r_estado;
    w_suma       = 1'b0;
    unique case (r_estado)
      VACIO:    if (bus.muestra) w_estado_sig = CONTANDO;
      CONTANDO: w_suma = bus.muestra;
      default:  w_estado_sig = VACIO;
    endcase
    // clear wins, but a simultaneous sample still becomes the reference
    if (bus.borrar) begin
      w_suma       = 1'b0;
      w_estado_sig = bus.muestra ? CONTANDO : VACIO;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CANALES; k++) begin
      w_dif[k] = r_prev[k] ^ bus.datos_in[k*ANCHO +: ANCHO];
      w_inc[k] = '0;
      for (int b = 0; b < ANCHO; b++)
        w_inc[k] = w_inc[k] + W_INC'(w_dif[k][b]);
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CANALES; k++) begin
      w_total[k]   = {1'b0, r_cnt[k]} + W_TOT'(w_inc[k]);
      w_cnt_sig[k] = r_cnt[k];
      w_sat_sig[k] = r_sat[k];
      if (w_suma) begin
        if (w_total[k] >= {1'b0, MAX_CNT}) begin
          w_cnt_sig[k] = MAX_CNT;
          w_sat_sig[k] = 1'b1;
        end else begin
          w_cnt_sig[k] = w_total[k][ANCHO_CNT-1:0];
        end
      end
      if (bus.borrar) begin
        w_cnt_sig[k] = '0;
        w_sat_sig[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= VACIO;
      r_sat    <= '0;
      for (int k = 0; k < NUM_CANALES; k++) begin
        r_prev[k] <= '0;
        r_cnt[k]  <= '0;
      end
    end else begin
      r_estado <= w_estado_sig;
      r_sat    <= w_sat_sig;
      for (int k = 0; k < NUM_CANALES; k++) begin
        if (bus.muestra)
          r_prev[k] <= bus.datos_in[k*ANCHO +: ANCHO];
        r_cnt[k] <= w_cnt_sig[k];
      end
    end
  end

  estado_r_t            r_rest, w_rest_sig;
  logic                 w_captura;
  logic                 w_fuera;
  logic [ANCHO_CNT-1:0] w_sel;
  logic [ANCHO_CNT-1:0] r_dato;
  logic                 r_err;

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_CANALES; k++)
      if (bus.dir == ANCHO_DIR'(k)) w_sel = r_cnt[k];
    w_fuera = (int'(bus.dir) >= NUM_CANALES);
  end

  always_comb begin
    w_rest_sig = r_rest;
    w_captura  = 1'b0;
    unique case (r_rest)
      R_IDLE: if (bus.lee) begin
        w_rest_sig = R_ENTREGA;
        w_captura  = 1'b1;
      end
      R_ENTREGA: w_rest_sig = R_IDLE;
      default:   w_rest_sig = R_IDLE;
    endcase
  end

  // value is taken at the lee edge, so it predates any same-cycle update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rest <= R_IDLE;
      r_dato <= '0;
      r_err  <= 1'b0;
    end else begin
      r_rest <= w_rest_sig;
      if (w_captura) begin
        r_dato <= w_fuera ? '0 : w_sel;
        r_err  <= w_fuera;
      end
    end
  end

  assign bus.listo    = (r_rest == R_ENTREGA);
  assign bus.err_dir  = bus.listo & r_err;
  assign bus.dato_out = r_dato;
  assign bus.saturado = r_sat;
endmodule

// File: tb/tb_monitor_transiciones.sv
// Bench for monitor_transiciones: vector table plus hand sequences,
// read results checked through an expected-value queue.
module tb_monitor_transiciones;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  monitor_transiciones_if #(.ANCHO(9), .NUM_CANALES(3),
    .ANCHO_CNT(32), .ANCHO_DIR(3)) b1 ();
  monitor_transiciones_if #(.ANCHO(9), .NUM_CANALES(3),
    .ANCHO_CNT(4), .ANCHO_DIR(3)) b2 ();

  monitor_transiciones #(.ANCHO(9), .NUM_CANALES(3),
    .ANCHO_CNT(32), .ANCHO_DIR(3)) u1 (
    .clk(clk), .reset(rst), .bus(b1));
  monitor_transiciones #(.ANCHO(9), .NUM_CANALES(3),
    .ANCHO_CNT(4), .ANCHO_DIR(3)) u2 (
    .clk(clk), .reset(rst), .bus(b2));

  typedef struct {
    int          op;
    logic [26:0] d;
    logic [2:0]  dir;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t        tbl[$];
  logic [32:0] q[$];
  int          n_chk = 0;
  int          n_err = 0;

  localparam int OP_S = 0, OP_CS = 1, OP_R = 2, OP_C = 3;

  function automatic logic [26:0] pk(input logic [8:0] c2,
                                     input logic [8:0] c1,
                                     input logic [8:0] c0);
    return {c2, c1, c0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (b1.listo) begin
      if (q.size() == 0) begin
        chk("spurious_listo", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = q.pop_front();
        chk("rd_dato", b1.dato_out, e[32:1]);
        chk("rd_err", 32'(b1.err_dir), 32'(e[0]));
      end
    end
  end

  task automatic samp(input logic [26:0] d, input logic clr);
    b1.datos_in = d;
    b1.muestra  = 1'b1;
    b1.borrar   = clr;
    tick();
    b1.muestra  = 1'b0;
    b1.borrar   = 1'b0;
  endtask

  task automatic leer(input logic [2:0] a, input logic [31:0] e,
                      input logic er);
    q.push_back({e, er});
    b1.lee = 1'b1;
    b1.dir = a;
    tick();
    b1.lee = 1'b0;
    tick();
    chk("rd_lat", q.size(), 0);
  endtask

  task automatic samp2(input logic [8:0] c1, input logic clr);
    b2.datos_in = pk(9'h0, c1, 9'h0);
    b2.muestra  = 1'b1;
    b2.borrar   = clr;
    tick();
    b2.muestra  = 1'b0;
    b2.borrar   = 1'b0;
  endtask

  task automatic leer2(input logic [31:0] e);
    b2.lee = 1'b1;
    b2.dir = 3'd1;
    tick();
    chk("rd2_listo", 32'(b2.listo), 32'd1);
    chk("rd2_dato", 32'(b2.dato_out), e);
    b2.lee = 1'b0;
    tick();
  endtask

  initial begin
    b1.datos_in = '0; b1.muestra = 0; b1.borrar = 0;
    b1.lee = 0; b1.dir = '0;
    b2.datos_in = '0; b2.muestra = 0; b2.borrar = 0;
    b2.lee = 0; b2.dir = '0;

    tbl.push_back('{OP_S,  pk(9'h000, 9'h000, 9'h000), 3'd0, 32'd0, 1'b0});
    tbl.push_back('{OP_S,  pk(9'h000, 9'h000, 9'h1FF), 3'd0, 32'd0, 1'b0});
    tbl.push_back('{OP_S,  pk(9'h000, 9'h000, 9'h1FF), 3'd0, 32'd0, 1'b0});
    tbl.push_back('{OP_S,  pk(9'h000, 9'h000, 9'h0AA), 3'd0, 32'd0, 1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd0, 32'd14, 1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd1, 32'd0,  1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd2, 32'd0,  1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd5, 32'd0,  1'b1});
    tbl.push_back('{OP_R,  27'd0, 3'd7, 32'd0,  1'b1});
    tbl.push_back('{OP_CS, pk(9'h1FF, 9'h1FF, 9'h1FF), 3'd0, 32'd0, 1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd0, 32'd0,  1'b0});
    tbl.push_back('{OP_S,  pk(9'h000, 9'h000, 9'h000), 3'd0, 32'd0, 1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd0, 32'd9,  1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd1, 32'd9,  1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd2, 32'd9,  1'b0});
    tbl.push_back('{OP_S,  pk(9'h100, 9'h001, 9'h0F0), 3'd0, 32'd0, 1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd0, 32'd13, 1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd1, 32'd10, 1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd2, 32'd10, 1'b0});
    tbl.push_back('{OP_C,  27'd0, 3'd0, 32'd0,  1'b0});
    tbl.push_back('{OP_S,  pk(9'h1FF, 9'h1FF, 9'h1FF), 3'd0, 32'd0, 1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd0, 32'd0,  1'b0});
    tbl.push_back('{OP_R,  27'd0, 3'd2, 32'd0,  1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_listo", 32'(b1.listo), 32'd0);
    chk("rst_err", 32'(b1.err_dir), 32'd0);
    chk("rst_dato", b1.dato_out, 32'd0);
    chk("rst_sat", 32'(b1.saturado), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      unique case (tbl[i].op)
        OP_S:  samp(tbl[i].d, 1'b0);
        OP_CS: samp(tbl[i].d, 1'b1);
        OP_C: begin
          b1.borrar = 1'b1;
          tick();
          b1.borrar = 1'b0;
        end
        default: leer(tbl[i].dir, tbl[i].exp, tbl[i].err);
      endcase
    end

    samp(pk(9'h000, 9'h000, 9'h000), 1'b0);
    b1.datos_in = pk(9'h1FF, 9'h1FF, 9'h1FF);
    b1.muestra  = 1'b1;
    q.push_back({32'd9, 1'b0});
    b1.lee = 1'b1;
    b1.dir = 3'd0;
    tick();
    b1.muestra = 1'b0;
    b1.lee     = 1'b0;
    tick();
    chk("same_cyc_lat", q.size(), 0);
    leer(3'd0, 32'd18, 1'b0);

    q.push_back({32'd18, 1'b0});
    q.push_back({32'd18, 1'b0});
    b1.lee = 1'b1;
    b1.dir = 3'd0;
    repeat (4) tick();
    b1.lee = 1'b0;
    tick();
    chk("b2b_cnt", q.size(), 0);

    q.push_back({32'd18, 1'b0});
    b1.lee = 1'b1;
    tick();
    b1.lee    = 1'b0;
    b1.borrar = 1'b1;
    tick();
    b1.borrar = 1'b0;
    chk("clr_rd_lat", q.size(), 0);
    leer(3'd0, 32'd0, 1'b0);

    samp(pk(9'h000, 9'h000, 9'h000), 1'b0);
    samp(pk(9'h1FF, 9'h1FF, 9'h1FF), 1'b0);
    leer(3'd1, 32'd9, 1'b0);
    b1.lee = 1'b1;
    b1.dir = 3'd1;
    tick();
    chk("pre_rst_listo", 32'(b1.listo), 32'd1);
    rst    = 1'b1;
    b1.lee = 1'b0;
    #1;
    chk("mid_rst_listo", 32'(b1.listo), 32'd0);
    chk("mid_rst_dato", b1.dato_out, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    leer(3'd1, 32'd0, 1'b0);
    samp(pk(9'h1FF, 9'h1FF, 9'h1FF), 1'b0);
    leer(3'd0, 32'd0, 1'b0);
    samp(pk(9'h000, 9'h000, 9'h000), 1'b0);
    leer(3'd2, 32'd9, 1'b0);

    samp2(9'h000, 1'b0);
    samp2(9'h1FF, 1'b0);
    chk("sat_9", 32'(b2.saturado), 32'd0);
    leer2(32'd9);
    samp2(9'h000, 1'b0);
    chk("sat_set", 32'(b2.saturado), 32'b010);
    leer2(32'd15);
    samp2(9'h1FF, 1'b0);
    chk("sat_sticky", 32'(b2.saturado), 32'b010);
    leer2(32'd15);
    b2.borrar = 1'b1;
    tick();
    b2.borrar = 1'b0;
    chk("sat_clr", 32'(b2.saturado), 32'd0);
    leer2(32'd0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/monitor_transiciones.md
Name: monitor_transiciones

Overview:
- Synthesizable transition-activity monitor placed directly downstream of the adder-under-test instances. It replaces the behavioural transition-counter memory used in simulation-only power estimation.
- Each cycle a sample strobe is asserted, it counts the bit toggles on each monitored adder output bus (sum plus carry) into a per-channel counter.
- Counters are read back through an addressed, request/acknowledge read port. A global clear command zeroes them.

Parameters:
- ANCHO, 9, bits per channel (8-bit sum plus carry-out).
- NUM_CANALES, 3, number of monitored channels (ripple, logic, lookahead); range 1..8.
- ANCHO_CNT, 32, width of each transition counter.
- ANCHO_DIR, 3, width of the read address; 2^ANCHO_DIR must be at least NUM_CANALES.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- datos_in  in  NUM_CANALES*ANCHO  monitored buses; channel k occupies bits [k*ANCHO +: ANCHO].
- muestra  in  1  sample strobe; datos_in is valid when high.
- borrar  in  1  clear request, one-cycle pulse.
- lee  in  1  read request.
- dir  in  ANCHO_DIR  read address (channel index).
- dato_out  out  ANCHO_CNT  read data.
- listo  out  1  read acknowledge, one-cycle pulse.
- err_dir  out  1  asserted together with listo when dir >= NUM_CANALES.
- saturado  out  NUM_CANALES  sticky per-channel saturation flag.

Behaviour:
- Reset (asynchronous, any time, including mid-read):
  - All counters 0, previous-sample registers 0, saturado 0.
  - dato_out 0, listo 0, err_dir 0.
  - Sampling FSM goes to VACIO; read FSM goes to R_IDLE.
- Sampling FSM:
  - VACIO: no reference sample held. When muestra=1, capture datos_in into the previous-sample registers, add nothing, go to CONTANDO.
  - CONTANDO: when muestra=1, for each channel k, counter[k] += popcount(prev[k] XOR cur[k]), then prev[k] <= cur[k]. Counters update in the cycle after the sampling edge. When muestra=0, hold.
  - borrar=1 in any state: all counters and saturado cleared, FSM goes to VACIO.
  - borrar and muestra in the same cycle: clear wins, the sample is captured as the new reference, FSM goes to CONTANDO, nothing is added.
- Arithmetic:
  - Per-sample increment is at most ANCHO and fits in ceil(log2(ANCHO+1)) bits.
  - Counters saturate at 2^ANCHO_CNT-1 and never wrap. The sticky saturado[k] sets on the cycle the counter reaches or would exceed the maximum, and holds until borrar or reset.
- Read FSM:
  - R_IDLE: when lee=1, latch dir and go to R_ENTREGA.
  - R_ENTREGA (one cycle):
    - dato_out = counter[dir_latched] as it stood at the end of the lee cycle, before any update from a muestra in that same cycle.
    - listo=1 for exactly one cycle, then return to R_IDLE.
    - Read latency is 1 cycle from lee to listo.
  - lee is ignored while in R_ENTREGA, so back-to-back requests give one acknowledge every 2 cycles.
  - dato_out holds its last value between reads.
  - Out-of-range dir: dato_out=0 and err_dir=1 for the listo cycle; otherwise err_dir=0.
  - borrar during R_ENTREGA: the read still returns the pre-clear value captured at lee.
- The sampling and read paths are independent; a read never stalls sampling.

Test Plan:
- Reset, then samples on channel 0 of 0x000, 0x1FF, 0x1FF, 0x0AA -> counter0 = 0+9+0+5 = 14; channels 1 and 2 stay 0. Read dir=0 -> listo 1 cycle later, dato_out=14, err_dir=0.
- After reset, a single sample of 0x1FF on all channels -> no count (VACIO reference only). Read each channel -> 0.
- borrar and muestra in the same cycle while counters are non-zero, followed by sample 0x000 -> all counters 0, then each counts 9. Read -> 9.
- ANCHO_CNT=4, toggle channel 1 between 0x000 and 0x1FF twice -> 9 then 18 saturates at 15; saturado[1]=1 and stays 1 after further samples, cleared by borrar.
- lee with dir=5 (NUM_CANALES=3) -> listo=1, err_dir=1, dato_out=0. A lee in the same cycle as muestra on dir=0 returns the pre-update value.
- Assert reset asynchronously mid-read (during R_ENTREGA) -> listo drops immediately, all counters 0, FSMs back in VACIO/R_IDLE.
